// File: rtl/demux_rr_feeder.sv
// Purpose: round-robin feeder steering BURST-bit slots from a serial stream to the enabled demux channels.
// Latency: 1 cycle from handshake to din/out_valid. All outputs are registered except in_ready.
// Backpressure: in_ready depends only on state, sel and ch_en. Stalls in SEND hold the slot open.
module demux_rr_feeder #(
  parameter int BURST = 4,
  parameter int GAP   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic       in_data,
  output logic       in_ready,
  input  logic [3:0] ch_en,
  output logic       din,
  output logic [1:0] sel,
  output logic       out_valid,
  output logic       slot_done,
  output logic       busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam logic [3:0] LAST_BEAT  = 4'(BURST - 1);
  localparam logic [2:0] LAST_GAP   = 3'(GAP - 1);
  // With no gap configured a finished or aborted slot goes straight back to the search.
  localparam state_t     AFTER_SLOT = (GAP == 0) ? ST_IDLE : ST_GAP;

  state_t     state_q, state_d;
  logic [1:0] ptr_q;
  logic [3:0] cnt_q;
  logic [2:0] gcnt_q;

  logic       hit;
  logic [1:0] pick;
  logic [1:0] cand;
  logic       xfer;
  logic       abort;
  logic       last_beat;
  logic       gap_done;

  // Round-robin search: scan from ptr+4 down to ptr+1 so the nearest enabled channel wins.
  always_comb begin
    hit  = 1'b0;
    pick = ptr_q;
    cand = ptr_q;
    for (int k = 4; k >= 1; k--) begin
      cand = ptr_q + 2'(k);
      if (ch_en[cand]) begin
        hit  = 1'b1;
        pick = cand;
      end
    end
  end

  assign in_ready  = (state_q == ST_SEND) && ch_en[sel];
  assign xfer      = in_ready && in_valid;
  assign abort     = (state_q == ST_SEND) && !ch_en[sel];
  assign last_beat = xfer && (cnt_q == LAST_BEAT);
  assign gap_done  = (gcnt_q == LAST_GAP);
  assign busy      = (state_q != ST_IDLE);

  // Next-state selection for the slot sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (hit) state_d = ST_SEND;
      ST_SEND: if (abort || last_beat) state_d = AFTER_SLOT;
      ST_GAP:  if (gap_done) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Datapath registers: output bit, channel select, pointer, beat and gap counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      din       <= 1'b0;
      sel       <= 2'b00;
      out_valid <= 1'b0;
      slot_done <= 1'b0;
      cnt_q     <= 4'd0;
      gcnt_q    <= 3'd0;
      ptr_q     <= 2'd3;
    end else begin
      out_valid <= xfer;
      slot_done <= last_beat;
      if (xfer) din <= in_data;
      if (state_q == ST_IDLE && hit) begin
        sel   <= pick;
        ptr_q <= pick;
      end
      if (abort || last_beat) cnt_q <= 4'd0;
      else if (xfer)          cnt_q <= cnt_q + 4'd1;
      if (state_q == ST_GAP)  gcnt_q <= gap_done ? 3'd0 : gcnt_q + 3'd1;
    end
  end

endmodule

// File: doc/demux_rr_feeder.md
# demux_rr_feeder

Round-robin feeder that sits directly upstream of the 1:4 demultiplexer (`demux_1to4`) and drives its `din` and `sel` inputs. It accepts a serial bit stream over a valid/ready handshake and steers fixed-length bursts of bits to each enabled output channel in turn. Between bursts it inserts a programmable idle gap. Its outputs connect straight to the demux; `out_valid` qualifies `din` for downstream consumers.

## Interface
- `BURST`, default 4: bits sent per channel slot. Legal range 1..16.
- `GAP`, default 1: idle cycles after each slot. Legal range 0..7.

- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `in_valid`, in, 1: upstream bit valid.
- `in_data`, in, 1: upstream bit.
- `in_ready`, out, 1: feeder accepts `in_data` this cycle.
- `ch_en`, in, 4: per-channel enable. Bit i enables demux output `y[i]`.
- `din`, out, 1: bit to the demux `din`.
- `sel`, out, 2: channel select to the demux `sel`.
- `out_valid`, out, 1: `din` holds a newly transferred bit.
- `slot_done`, out, 1: one-cycle pulse when a slot completes normally.
- `busy`, out, 1: high whenever the FSM is not in IDLE.

## Operation
- **Reset values.** `state`=IDLE, `din`=0, `sel`=00, `out_valid`=0, `slot_done`=0, burst count=0, gap count=0, pointer=3. With pointer=3 the first search starts at channel 0.
- **FSM states:** IDLE, SEND, GAP.
- **IDLE**
  - Searches channels pointer+1, +2, +3, +4 (mod 4) and picks the first with `ch_en` set.
  - On a hit, registers that channel into `sel` and pointer, then goes to SEND.
  - If `ch_en`=0000, stays in IDLE.
- **`in_ready`** = (state==SEND) && `ch_en[sel]`. It is combinational from registered state, `sel` and `ch_en` only. There is never a path from `in_valid` to `in_ready`.
- **Transfer** happens when `in_valid && in_ready`.
  - Next cycle: `din`=`in_data`, `out_valid`=1, burst count increments.
  - Cycles without a transfer: `out_valid`=0 and `din` holds its last value.
- **Normal slot end.** On the transfer where burst count == BURST-1:
  - Count clears.
  - `slot_done`=1 on the next cycle, the same cycle as the final `out_valid`.
  - FSM goes to GAP, or to IDLE when GAP=0.
- **Abort.** If `ch_en[sel]` is 0 during SEND:
  - No transfer occurs that cycle.
  - Burst count clears and the FSM goes to GAP, or to IDLE when GAP=0.
  - `slot_done` is not asserted.
- **GAP.** `out_valid`=0 and `in_ready`=0 for exactly GAP cycles, then the FSM goes to IDLE.
- **`sel` stability.** `sel` changes only on the IDLE→SEND transition. It holds through SEND, GAP and IDLE until the next selection.
- **`ch_en` changes outside SEND.** Changes during GAP or IDLE affect only the next search.
- **Mid-operation reset.** `rst_n` low in any state returns everything to reset values at that edge. A handshake coincident with `rst_n` low is discarded.

## Timing
- **Latency.** Handshake to `din`/`out_valid` is 1 cycle. All outputs are registered except `in_ready`.
- **Minimum slot period.** With continuous `in_valid`, a slot takes BURST + GAP + 1 cycles from first `in_ready` to the next first `in_ready`:
  - BURST transfer cycles,
  - GAP idle cycles,
  - 1 IDLE selection cycle.
- **Throughput.** Within a slot, one bit per cycle.
- **Reset.** First `in_ready` occurs 2 cycles after `rst_n` rises, given `ch_en`≠0: one cycle in IDLE, then SEND.

## Test plan
All scenarios use BURST=4, GAP=1.

1. **Reset hold.** `rst_n`=0 for 2 cycles with `in_valid`=1 and `ch_en`=1111 → `din`=0, `sel`=00, `out_valid`=0, `in_ready`=0, `busy`=0, `slot_done`=0.
2. **Full rotation.** `ch_en`=1111, `in_valid` held 1, `in_data` pattern 1,0,1,1 repeating →
   - `sel` steps 00,01,10,11,00.
   - Each slot shows 4 `out_valid` cycles with `din`=1,0,1,1, each one cycle after its handshake.
   - `slot_done` is high with the 4th `out_valid`.
   - 2 dead cycles between slots; period 6 cycles.
3. **Sparse enables.** `ch_en`=1010 → `sel` alternates 01,11,01,11; channels 00 and 10 are never selected.
4. **Backpressure.** `in_valid` toggles 1,0,1,0 → a slot needs 8 SEND cycles; count advances only on handshakes; `out_valid` alternates.
5. **Abort and empty enable.**
   - Clear `ch_en[sel]` after 2 transfers → `in_ready` drops the same cycle, no `slot_done`, 1 GAP cycle, then the next enabled channel is selected.
   - Set `ch_en`=0000 → FSM stays in IDLE, `busy`=0.
6. **Reset mid-slot.** Assert `rst_n`=0 after 2 transfers on channel 10 → all outputs return to reset values at that edge. After release, the first selected `sel` is 00.
